bist_response_analyzer: RTL
===========================

# bist_response_analyzer

BIST datapath that sits on the far side of the BIST `controller`. It consumes the `init`/`running`/`toggle`/`finish` sequence and generates pseudo-random patterns for the circuit under test (CUT) with a Galois LFSR. It compacts the CUT responses into a MISR signature and, at `finish`, compares that signature against a golden value to report pass/fail.

## Interface
Parameters:
- `PAT_W`, 8: pattern width (LFSR width).
- `SIG_W`, 8: signature width (MISR width, also CUT response width).
- `LFSR_TAPS`, 8'h1D: Galois feedback mask for the LFSR.
- `LFSR_SEED`, 8'h01: LFSR load value on `init`; must be nonzero.
- `MISR_TAPS`, 8'h1D: Galois feedback mask for the MISR.
- `GOLDEN_SIG`, 8'h00: expected final signature.
- `CNT_W`, 16: pattern counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `init` in 1: controller init pulse.
- `running` in 1: controller run level.
- `toggle` in 1: controller phase-toggle pulse.
- `finish` in 1: controller end-of-test pulse.
- `cut_resp` in SIG_W: CUT response to the current `pattern`.
- `pattern` out PAT_W: stimulus to the CUT.
- `signature` out SIG_W: current MISR contents.
- `pat_count` out CNT_W: patterns applied since `init`.
- `result_valid` out 1: pass/fail is valid.
- `pass` out 1: signature matched `GOLDEN_SIG`.
- `fail` out 1: signature mismatched.

## Operation
- States:
  - IDLE: after reset.
  - ARMED: after `init`.
  - RUN: while `running`=1.
  - DONE: after `finish`.
- Transitions:
  - `init` from any state -> ARMED.
  - ARMED with `running`=1 -> RUN.
  - RUN with `running`=0 -> ARMED.
  - ARMED or RUN with `finish`=1 -> DONE.
  - DONE -> ARMED only on `init`.
- `init` has the highest priority and overrides all other inputs in the same cycle. It performs these loads:
  - lfsr <= LFSR_SEED.
  - misr <= 0.
  - phase <= 0.
  - pat_count <= 0.
  - result_valid, pass and fail <= 0.
- When `running`=1 in ARMED or RUN (and no `init`):
  - lfsr <= {lfsr[PAT_W-2:0],0} ^ (lfsr[PAT_W-1] ? LFSR_TAPS : 0).
  - misr <= {misr[SIG_W-2:0],0} ^ (misr[SIG_W-1] ? MISR_TAPS : 0) ^ cut_resp.
  - pat_count increments, saturating at all-ones.
- `pattern` = lfsr ^ {PAT_W{phase}}; phase 1 applies inverted patterns.
- `toggle` in ARMED or RUN flips `phase`. If it coincides with `running`, the LFSR/MISR step still happens and the new phase takes effect on the next pattern.
- `finish` in ARMED or RUN:
  - If `running` is also 1, the final MISR update includes this cycle's `cut_resp`.
  - The compare uses that updated value.
  - Sets result_valid=1 and pass=(sig==GOLDEN_SIG), fail=!pass.
- In DONE, `running`, `toggle` and `finish` are ignored. Outputs hold until `init`.
- In IDLE, everything except `init` is ignored.
- Lock-up guard: if the LFSR ever holds 0, its next value is 1.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - lfsr = LFSR_SEED, so `pattern` = LFSR_SEED.
  - misr = 0, phase = 0, pat_count = 0.
  - result_valid = 0, pass = 0, fail = 0.
- `pattern` equals LFSR_SEED in the cycle after `init`.
- The CUT is combinational. `cut_resp` is sampled on the same edge on which `pattern` advances.
- Latency from the `finish` edge to result_valid/pass/fail is 1 cycle.
- Reset mid-run (asserting `reset` low) returns to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `bist_pkg` holds:
  - the state enum localparams (IDLE/ARMED/RUN/DONE);
  - default tap and seed constants, shared with the controller bench.
- One sub-module, `galois_shift_reg`, is parameterised by width and taps with an optional parallel XOR input. It is instantiated twice: as the LFSR (XOR input tied to 0) and as the MISR.

## Test plan
- Reset, then `init`, then 8 cycles of `running` with defaults -> pattern sequence 01,02,04,08,10,20,40,80, then 1D; pat_count=8.
- As above, plus a `toggle` pulse after the 8th cycle -> pattern=E2.
- `cut_resp`=0 throughout, then `finish` -> signature=00, pass=1, fail=0 and result_valid=1 one cycle after `finish`.
- `cut_resp`=01 for one cycle from misr=0, then `finish` -> signature=01, fail=1, pass=0.
- `running`, `toggle` and `finish` while IDLE, or after DONE -> no change in pattern, signature or pat_count.
- Reset asserted mid-RUN -> all outputs return to reset values immediately. A subsequent `init` with `init` and `finish` asserted together -> ARMED with result_valid=0, because `init` wins.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller-facing states
// and default LFSR/MISR constants.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam logic [7:0] DEF_LFSR_TAPS = 8'h1D;
  localparam logic [7:0] DEF_LFSR_SEED = 8'h01;
  localparam logic [7:0] DEF_MISR_TAPS = 8'h1D;
  localparam logic [7:0] DEF_GOLDEN    = 8'h00;

endpackage

// File: rtl/galois_shift_reg.sv
// Galois shift register with parallel XOR input.
// Serves as the pattern LFSR and the response MISR.
module galois_shift_reg #(
  parameter int unsigned    W     = 8,
  parameter logic [W-1:0]   TAPS  = 8'h1D,
  parameter logic [W-1:0]   SEED  = '0,
  parameter bit             GUARD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r;

  assign nxt = {r[W-2:0], 1'b0}
             ^ (r[W-1] ? TAPS : '0)
             ^ din;
  assign q   = r;

  // Load seed, escape the all-zero lock-up, or shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= SEED;
    end else if (load) begin
      r <= SEED;
    end else if (GUARD && (r == '0)) begin
      r <= ONE;
    end else if (step) begin
      r <= nxt;
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST datapath: LFSR stimulus, MISR compaction
// and golden-signature compare on finish.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned        PAT_W      = 8,
  parameter int unsigned        SIG_W      = 8,
  parameter logic [PAT_W-1:0]   LFSR_TAPS  = DEF_LFSR_TAPS,
  parameter logic [PAT_W-1:0]   LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [SIG_W-1:0]   MISR_TAPS  = DEF_MISR_TAPS,
  parameter logic [SIG_W-1:0]   GOLDEN_SIG = DEF_GOLDEN,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             toggle,
  input  logic             finish,
  input  logic [SIG_W-1:0] cut_resp,
  output logic [PAT_W-1:0] pattern,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count,
  output logic             result_valid,
  output logic             pass,
  output logic             fail
);

  bist_state_t      state;
  logic             phase;
  logic             active;
  logic             step;
  logic [PAT_W-1:0] lfsr_q;
  logic [PAT_W-1:0] lfsr_nxt;
  logic [SIG_W-1:0] misr_nxt;
  logic [SIG_W-1:0] final_sig;

  assign active = !init
               && ((state == ARMED) || (state == RUN));
  assign step   = active && running;

  // A finish that coincides with a run cycle compares
  // the signature including this cycle's response.
  assign final_sig = step ? misr_nxt : signature;

  assign pattern = lfsr_q ^ {PAT_W{phase}};

  galois_shift_reg #(
    .W     (PAT_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED),
    .GUARD (1'b1)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (init),
    .step  (step),
    .din   ('0),
    .q     (lfsr_q),
    .nxt   (lfsr_nxt)
  );

  galois_shift_reg #(
    .W     (SIG_W),
    .TAPS  (MISR_TAPS),
    .SEED  ('0),
    .GUARD (1'b0)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .load  (init),
    .step  (step),
    .din   (cut_resp),
    .q     (signature),
    .nxt   (misr_nxt)
  );

  // Sequencing FSM with phase, counter and verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      phase        <= 1'b0;
      pat_count    <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
    end else if (init) begin
      state        <= ARMED;
      phase        <= 1'b0;
      pat_count    <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
    end else if (active) begin
      if (toggle) begin
        phase <= ~phase;
      end
      if (running && (pat_count != '1)) begin
        pat_count <= pat_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (finish) begin
        state        <= DONE;
        result_valid <= 1'b1;
        pass         <= (final_sig == GOLDEN_SIG);
        fail         <= (final_sig != GOLDEN_SIG);
      end else if (running) begin
        state <= RUN;
      end else begin
        state <= ARMED;
      end
    end
  end

endmodule
